restoring_divider_32_bit: RTL and testbench

RESTORING_DIVIDER_32_BIT -- requirements
Module: restoring_divider_32_bit

---
 rtl/restoring_divider_32_bit_pkg.sv | 18 +
 rtl/restoring_divider_32_bit_subtractor.sv | 19 +
 rtl/restoring_divider_32_bit.sv | 131 +++++++++++++
 tb/tb_restoring_divider_32_bit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_32_bit_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding,
// default operand width and the number of shift/subtract iterations.
package restoring_divider_32_bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int ITERATIONS         = 32;
  localparam int CNT_W              = 6;

  // Counter value seen on the final RUN edge.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

endpackage

// File: rtl/restoring_divider_32_bit_subtractor.sv
// Combinational trial subtractor used by the restoring divider.
// Ports:
//   A          : minuend
//   B          : subtrahend
//   Difference : A - B (modulo 2^WIDTH)
//   Borrow_Out : 1 when A < B
module subtractor_33_bit #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow_Out
);

  // One extra bit on the left captures the borrow of the subtraction.
  assign {Borrow_Out, Difference} = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/restoring_divider_32_bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   Clk, Reset       : clock and synchronous active-high reset
//   Start_In         : begin a division (accepted only in IDLE)
//   Dividend_In      : unsigned dividend, captured on the accepting edge
//   Divisor_In       : unsigned divisor, captured on the accepting edge
//   Quotient_Out     : quotient of the last completed division
//   Remainder_Out    : remainder of the last completed division
//   Busy_Out         : high while in RUN or DONE
//   Done_Out         : one-cycle completion pulse
//   Div_By_Zero_Out  : set on completion of a zero-divisor request, held
//                      until the next accept
module restoring_divider_32_bit
  import restoring_divider_32_bit_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Dividend_In,
  input  logic [DATA_WIDTH-1:0] Divisor_In,
  output logic [DATA_WIDTH-1:0] Quotient_Out,
  output logic [DATA_WIDTH-1:0] Remainder_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  Div_By_Zero_Out
);

  state_t                state;
  logic [CNT_W-1:0]      iter_cnt;
  logic [DATA_WIDTH-1:0] rem_q;
  // Dividend shift register; quotient bits enter at the LSB as dividend
  // bits leave at the MSB, so after the last iteration it holds the quotient.
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;

  logic [DATA_WIDTH:0]   shifted_rem;
  logic [DATA_WIDTH:0]   trial_diff;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] next_rem;
  logic [DATA_WIDTH-1:0] next_quo;
  logic                  accept;
  logic                  unused_diff_msb;

  assign accept = (state == IDLE) && Start_In;

  // The 33-bit path keeps the shifted remainder exact when the divisor
  // has its MSB set.
  assign shifted_rem = {rem_q, dividend_q[DATA_WIDTH-1]};

  subtractor_33_bit #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_trial_sub (
    .A          (shifted_rem),
    .B          ({1'b0, divisor_q}),
    .Difference (trial_diff),
    .Borrow_Out (borrow)
  );

  // Without a borrow the difference is below the divisor, so its MSB is
  // always zero; on a borrow the shifted remainder is restored.
  assign next_rem        = borrow ? shifted_rem[DATA_WIDTH-1:0] : trial_diff[DATA_WIDTH-1:0];
  assign next_quo        = {dividend_q[DATA_WIDTH-2:0], ~borrow};
  assign unused_diff_msb = trial_diff[DATA_WIDTH];

  // Operand datapath: no reset needed, contents only matter after accept.
  always_ff @(posedge Clk) begin
    if (accept) begin
      dividend_q <= Dividend_In;
      divisor_q  <= Divisor_In;
    end else if (state == RUN) begin
      dividend_q <= next_quo;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      iter_cnt        <= '0;
      rem_q           <= '0;
      Quotient_Out    <= '0;
      Remainder_Out   <= '0;
      Busy_Out        <= 1'b0;
      Done_Out        <= 1'b0;
      Div_By_Zero_Out <= 1'b0;
    end else begin
      Done_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_In) begin
            iter_cnt        <= '0;
            rem_q           <= '0;
            Busy_Out        <= 1'b1;
            Div_By_Zero_Out <= 1'b0;
            if (Divisor_In == '0) begin
              // Zero divisor completes immediately with saturated quotient.
              Quotient_Out    <= '1;
              Remainder_Out   <= Dividend_In;
              Div_By_Zero_Out <= 1'b1;
              Done_Out        <= 1'b1;
              state           <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem_q    <= next_rem;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_ITER) begin
            Quotient_Out  <= next_quo;
            Remainder_Out <= next_rem;
            Done_Out      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          Busy_Out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          Busy_Out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_32_bit.sv
// Directed bench for restoring_divider_32_bit.
// Edge numbering: the accepting edge is edge 1; a nonzero-divisor result
// must first show Done_Out after edge 33, a zero-divisor result after edge 1.
module tb_restoring_divider_32_bit;

  logic        Clk;
  logic        Reset;
  logic        Start_In;
  logic [31:0] Dividend_In;
  logic [31:0] Divisor_In;
  logic [31:0] Quotient_Out;
  logic [31:0] Remainder_Out;
  logic        Busy_Out;
  logic        Done_Out;
  logic        Div_By_Zero_Out;

  int n_pass  = 0;
  int n_total = 0;

  restoring_divider_32_bit #(.DATA_WIDTH(32)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Start_In        (Start_In),
    .Dividend_In     (Dividend_In),
    .Divisor_In      (Divisor_In),
    .Quotient_Out    (Quotient_Out),
    .Remainder_Out   (Remainder_Out),
    .Busy_Out        (Busy_Out),
    .Done_Out        (Done_Out),
    .Div_By_Zero_Out (Div_By_Zero_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Accept a request and wait for Done_Out; returns the edge count.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int edges);
    Dividend_In = a;
    Divisor_In  = b;
    Start_In    = 1'b1;
    @(posedge Clk); #1;
    Start_In    = 1'b0;
    // Operands may change freely once accepted.
    Dividend_In = 32'hDEADBEEF;
    Divisor_In  = 32'h00000003;
    edges = 1;
    while (!Done_Out && edges < 100) begin
      @(posedge Clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start_In = 1'b0; Dividend_In = '0; Divisor_In = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    n_total++; if (Quotient_Out !== 32'd0) $display("FAIL reset_q got %h want 0", Quotient_Out); else n_pass++;
    n_total++; if (Remainder_Out !== 32'd0) $display("FAIL reset_r got %h want 0", Remainder_Out); else n_pass++;
    n_total++; if (Busy_Out !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy_Out); else n_pass++;
    n_total++; if (Done_Out !== 1'b0) $display("FAIL reset_done got %b want 0", Done_Out); else n_pass++;
    n_total++; if (Div_By_Zero_Out !== 1'b0) $display("FAIL reset_dbz got %b want 0", Div_By_Zero_Out); else n_pass++;
  endtask

  task automatic test_basic();
    int e;
    do_div(32'd100, 32'd7, e);
    n_total++; if (e != 33) $display("FAIL basic_latency got %0d want 33", e); else n_pass++;
    n_total++; if (Quotient_Out !== 32'd14) $display("FAIL basic_q got %0d want 14", Quotient_Out); else n_pass++;
    n_total++; if (Remainder_Out !== 32'd2) $display("FAIL basic_r got %0d want 2", Remainder_Out); else n_pass++;
    n_total++; if (Div_By_Zero_Out !== 1'b0) $display("FAIL basic_dbz got %b want 0", Div_By_Zero_Out); else n_pass++;
    n_total++; if (Busy_Out !== 1'b1) $display("FAIL basic_busy_done got %b want 1", Busy_Out); else n_pass++;
    @(posedge Clk); #1;
    n_total++; if (Done_Out !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", Done_Out); else n_pass++;
    n_total++; if (Busy_Out !== 1'b0) $display("FAIL basic_busy_idle got %b want 0", Busy_Out); else n_pass++;
    n_total++; if (Quotient_Out !== 32'd14) $display("FAIL basic_q_hold got %0d want 14", Quotient_Out); else n_pass++;
  endtask

  task automatic test_extremes();
    int e;
    do_div(32'hFFFFFFFF, 32'd1, e);
    n_total++; if (e != 33) $display("FAIL max_by_1_latency got %0d want 33", e); else n_pass++;
    n_total++; if (Quotient_Out !== 32'hFFFFFFFF) $display("FAIL max_by_1_q got %h want ffffffff", Quotient_Out); else n_pass++;
    n_total++; if (Remainder_Out !== 32'd0) $display("FAIL max_by_1_r got %h want 0", Remainder_Out); else n_pass++;
    @(posedge Clk); #1;
    do_div(32'hFFFFFFFF, 32'h80000000, e);
    n_total++; if (e != 33) $display("FAIL max_by_msb_latency got %0d want 33", e); else n_pass++;
    n_total++; if (Quotient_Out !== 32'd1) $display("FAIL max_by_msb_q got %h want 1", Quotient_Out); else n_pass++;
    n_total++; if (Remainder_Out !== 32'h7FFFFFFF) $display("FAIL max_by_msb_r got %h want 7fffffff", Remainder_Out); else n_pass++;
    @(posedge Clk); #1;
    do_div(32'd0, 32'd9, e);
    n_total++; if (Quotient_Out !== 32'd0 || Remainder_Out !== 32'd0)
      $display("FAIL zero_dividend got %0d/%0d want 0/0", Quotient_Out, Remainder_Out); else n_pass++;
    @(posedge Clk); #1;
  endtask

  task automatic test_div_by_zero();
    int e;
    do_div(32'd5, 32'd0, e);
    n_total++; if (e != 1) $display("FAIL dbz_latency got %0d want 1", e); else n_pass++;
    n_total++; if (Quotient_Out !== 32'hFFFFFFFF) $display("FAIL dbz_q got %h want ffffffff", Quotient_Out); else n_pass++;
    n_total++; if (Remainder_Out !== 32'd5) $display("FAIL dbz_r got %0d want 5", Remainder_Out); else n_pass++;
    n_total++; if (Div_By_Zero_Out !== 1'b1) $display("FAIL dbz_flag got %b want 1", Div_By_Zero_Out); else n_pass++;
    @(posedge Clk); #1;
    n_total++; if (Div_By_Zero_Out !== 1'b1 || Done_Out !== 1'b0)
      $display("FAIL dbz_hold got dbz=%b done=%b want dbz=1 done=0", Div_By_Zero_Out, Done_Out); else n_pass++;
    // The next accept clears the flag.
    Dividend_In = 32'd8; Divisor_In = 32'd2; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    n_total++; if (Div_By_Zero_Out !== 1'b0) $display("FAIL dbz_clear got %b want 0", Div_By_Zero_Out); else n_pass++;
    e = 0;
    while (!Done_Out && e < 100) begin @(posedge Clk); #1; e++; end
    n_total++; if (Quotient_Out !== 32'd4) $display("FAIL after_dbz_q got %0d want 4", Quotient_Out); else n_pass++;
    @(posedge Clk); #1;
  endtask

  task automatic test_start_in_run();
    int dones = 0;
    int first = 0;
    logic [31:0] q_at = '0, r_at = '0;
    Dividend_In = 32'd3; Divisor_In = 32'd10; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    for (int i = 2; i <= 80; i++) begin
      if (i == 11) begin
        Dividend_In = 32'd50; Divisor_In = 32'd5; Start_In = 1'b1;
      end else begin
        Start_In = 1'b0;
      end
      @(posedge Clk); #1;
      if (Done_Out) begin
        dones++;
        if (dones == 1) begin first = i; q_at = Quotient_Out; r_at = Remainder_Out; end
      end
    end
    Start_In = 1'b0;
    n_total++; if (dones != 1) $display("FAIL ignore_start_dones got %0d want 1", dones); else n_pass++;
    n_total++; if (first != 33) $display("FAIL ignore_start_latency got %0d want 33", first); else n_pass++;
    n_total++; if (q_at !== 32'd0 || r_at !== 32'd3)
      $display("FAIL ignore_start_result got %0d/%0d want 0/3", q_at, r_at); else n_pass++;
    n_total++; if (Busy_Out !== 1'b0) $display("FAIL ignore_start_idle got busy=%b want 0", Busy_Out); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int e;
    int dones = 0;
    do_div(32'd77, 32'd4, e);
    n_total++; if (Quotient_Out !== 32'd19 || Remainder_Out !== 32'd1)
      $display("FAIL pre_reset got %0d/%0d want 19/1", Quotient_Out, Remainder_Out); else n_pass++;
    @(posedge Clk); #1;
    Dividend_In = 32'd1000; Divisor_In = 32'd3; Start_In = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0;
    repeat (19) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    n_total++; if (Quotient_Out !== 32'd0 || Remainder_Out !== 32'd0)
      $display("FAIL midrun_reset_result got %0d/%0d want 0/0", Quotient_Out, Remainder_Out); else n_pass++;
    n_total++; if (Busy_Out !== 1'b0 || Done_Out !== 1'b0 || Div_By_Zero_Out !== 1'b0)
      $display("FAIL midrun_reset_flags got busy=%b done=%b dbz=%b want 0", Busy_Out, Done_Out, Div_By_Zero_Out); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done_Out) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL midrun_reset_no_done got %0d want 0", dones); else n_pass++;
    // Reset wins over a simultaneous start.
    Dividend_In = 32'd9; Divisor_In = 32'd2; Start_In = 1'b1; Reset = 1'b1;
    @(posedge Clk); #1;
    Start_In = 1'b0; Reset = 1'b0;
    n_total++; if (Busy_Out !== 1'b0) $display("FAIL reset_over_start got busy=%b want 0", Busy_Out); else n_pass++;
    do_div(32'd1000, 32'd3, e);
    n_total++; if (e != 33) $display("FAIL after_reset_latency got %0d want 33", e); else n_pass++;
    n_total++; if (Quotient_Out !== 32'd333 || Remainder_Out !== 32'd1)
      $display("FAIL after_reset_result got %0d/%0d want 333/1", Quotient_Out, Remainder_Out); else n_pass++;
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    int e;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      do_div(a, b, e);
      n_total++; if (e != 33) $display("FAIL rand%0d_latency got %0d want 33", i, e); else n_pass++;
      n_total++; if (Quotient_Out !== a / b)
        $display("FAIL rand%0d_q %h/%h got %h want %h", i, a, b, Quotient_Out, a / b); else n_pass++;
      n_total++; if (Remainder_Out !== a % b)
        $display("FAIL rand%0d_r %h/%h got %h want %h", i, a, b, Remainder_Out, a % b); else n_pass++;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_start_in_run();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
